// File: rtl/dds_btn_ctrl.sv
// DDS front-panel controller: debounced UP/DN/MODE presses become FTW, waveform and step-size config.
// Latency: a decoded press updates the config registers at that edge; CfgValid_o is high the next cycle.
// Backpressure: config held stable while CfgValid_o & ~CfgReady_i; counters freeze and events drop meanwhile.
module dds_btn_ctrl #(
  parameter int               FTW_W      = 32,
  parameter logic [FTW_W-1:0] FTW_INIT   = FTW_W'(1000),
  parameter logic [FTW_W-1:0] FTW_MIN    = FTW_W'(1),
  parameter logic [FTW_W-1:0] FTW_MAX    = FTW_W'(64'h8000_0000),
  parameter logic [FTW_W-1:0] STEP_BASE  = FTW_W'(1),
  parameter int               HOLD_CYC   = 2**22,
  parameter int               REPEAT_CYC = 2**21
) (
  input  logic             Fg_CLK,
  input  logic             RESET,
  input  logic             BtnUp_n,
  input  logic             BtnDn_n,
  input  logic             BtnMode_n,
  input  logic             CfgReady_i,
  output logic [FTW_W-1:0] Ftw_o,
  output logic [1:0]       Wave_o,
  output logic [1:0]       StepSel_o,
  output logic             CfgValid_o
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    REPEAT = 3'd2,
    MHOLD  = 3'd3,
    MWAIT  = 3'd4,
    COMMIT = 3'd5
  } state_t;

  state_t state, state_nx;

  logic up_q, dn_q, md_q;
  logic up_p, dn_p, md_p;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic sel_dn, sel_nx;
  logic init_done, init_nx;
  logic [FTW_W-1:0] ftw_nx;
  logic [1:0] wave_nx, stepsel_nx;
  logic valid_nx;

  logic [FTW_W:0]   step_w, sum_w, floor_w;
  logic [FTW_W-1:0] diff_w, ftw_up, ftw_dn, ftw_stp;
  logic can_load, held, all_rel_p;

  // Register each button once and keep the previous sample; both reset to "released"
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      up_q <= 1'b1;
      dn_q <= 1'b1;
      md_q <= 1'b1;
      up_p <= 1'b1;
      dn_p <= 1'b1;
      md_p <= 1'b1;
    end else begin
      up_q <= BtnUp_n;
      dn_q <= BtnDn_n;
      md_q <= BtnMode_n;
      up_p <= up_q;
      dn_p <= dn_q;
      md_p <= md_q;
    end
  end

  // Step size and clamped up/down candidates, one bit wider so nothing wraps
  always_comb begin
    step_w  = {1'b0, STEP_BASE} << {StepSel_o, 2'b00};
    sum_w   = {1'b0, Ftw_o} + step_w;
    floor_w = step_w + {1'b0, FTW_MIN};
    diff_w  = Ftw_o - step_w[FTW_W-1:0];
    ftw_up  = (sum_w > {1'b0, FTW_MAX}) ? FTW_MAX : sum_w[FTW_W-1:0];
    ftw_dn  = ({1'b0, Ftw_o} < floor_w) ? FTW_MIN : diff_w;
    ftw_stp = sel_dn ? ftw_dn : ftw_up;
  end

  // Output registers may only be reloaded when nothing is stuck waiting for the core
  assign can_load  = ~CfgValid_o | CfgReady_i;
  assign held      = sel_dn ? ~dn_q : ~up_q;
  // A new action needs every button released in the previous cycle
  assign all_rel_p = up_p & dn_p & md_p;

  // FSM state register
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and config decode; a clamped step leaves outputs and valid untouched
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sel_nx     = sel_dn;
    init_nx    = init_done;
    ftw_nx     = Ftw_o;
    wave_nx    = Wave_o;
    stepsel_nx = StepSel_o;
    valid_nx   = CfgValid_o & ~CfgReady_i;
    unique case (state)
      IDLE: begin
        if (!init_done) begin
          // first cycle out of reset: push the defaults
          init_nx  = 1'b1;
          valid_nx = 1'b1;
          state_nx = COMMIT;
        end else if (all_rel_p && !up_q) begin
          sel_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = HOLD;
          if (can_load && (ftw_up != Ftw_o)) begin
            ftw_nx   = ftw_up;
            valid_nx = 1'b1;
          end
        end else if (all_rel_p && !dn_q) begin
          sel_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = HOLD;
          if (can_load && (ftw_dn != Ftw_o)) begin
            ftw_nx   = ftw_dn;
            valid_nx = 1'b1;
          end
        end else if (all_rel_p && !md_q) begin
          cnt_nx   = '0;
          state_nx = MHOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (can_load) begin
          if (cnt == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
            cnt_nx   = '0;
            state_nx = REPEAT;
            if (ftw_stp != Ftw_o) begin
              ftw_nx   = ftw_stp;
              valid_nx = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      MHOLD: begin
        if (md_q) begin
          // short press: cycle waveform
          state_nx = IDLE;
          if (can_load) begin
            wave_nx  = Wave_o + 2'd1;
            valid_nx = 1'b1;
          end
        end else if (can_load) begin
          if (cnt == HOLD_LAST) begin
            // long press: cycle step size, then wait for release
            stepsel_nx = StepSel_o + 2'd1;
            valid_nx   = 1'b1;
            state_nx   = MWAIT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      MWAIT: begin
        if (md_q) state_nx = IDLE;
      end
      COMMIT: begin
        if (CfgReady_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter, tracked button and config output registers
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      sel_dn     <= 1'b0;
      init_done  <= 1'b0;
      Ftw_o      <= FTW_INIT;
      Wave_o     <= 2'd0;
      StepSel_o  <= 2'd0;
      CfgValid_o <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      sel_dn     <= sel_nx;
      init_done  <= init_nx;
      Ftw_o      <= ftw_nx;
      Wave_o     <= wave_nx;
      StepSel_o  <= stepsel_nx;
      CfgValid_o <= valid_nx;
    end
  end

endmodule
